// File: rtl/serial_word_rx.sv
// Deserialises an en-framed MSB-first bit stream into WIDTH-bit words; word visible 1 cycle after last bit.
// No backpressure: every en=1 edge consumes a bit; dropping en mid-word aborts the frame (frame_err).
// Optional trailing even-parity bit per frame: define SERIAL_WORD_RX_PARITY_EN.
module serial_word_rx #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             d,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             frame_err,
    output logic             parity_err,
    output logic             busy
);

`ifdef SERIAL_WORD_RX_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    // Holds every bit of the frame except the one sampled on the completing edge.
    localparam int SHW = FRAME - 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [SHW-1:0]   shreg, shreg_n;
    logic [WIDTH-1:0] word_n;
    logic             wv_n, fe_n;
    logic [SHW-1:0]   shreg_shifted;
    logic [WIDTH-1:0] data_done;

    assign shreg_shifted = (shreg << 1) | SHW'(d);

`ifdef SERIAL_WORD_RX_PARITY_EN
    logic pe_q, pe_n;
    assign data_done  = shreg;
    assign parity_err = pe_q;
`else
    assign data_done  = {shreg, d};
    assign parity_err = 1'b0;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shreg_n = shreg;
        word_n  = word_out;
        wv_n    = 1'b0;
        fe_n    = 1'b0;
`ifdef SERIAL_WORD_RX_PARITY_EN
        pe_n    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (en) begin
                    shreg_n = shreg_shifted;
                    cnt_n   = CNT_W'(1);
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (!en) begin
                    fe_n    = 1'b1;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else if (cnt == CNT_W'(FRAME - 1)) begin
                    word_n  = data_done;
                    wv_n    = 1'b1;
                    cnt_n   = '0;
                    state_n = IDLE;
`ifdef SERIAL_WORD_RX_PARITY_EN
                    pe_n    = (^shreg) ^ d;
`endif
                end else begin
                    shreg_n = shreg_shifted;
                    cnt_n   = cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
`ifdef SERIAL_WORD_RX_PARITY_EN
            pe_q       <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            shreg      <= shreg_n;
            word_out   <= word_n;
            word_valid <= wv_n;
            frame_err  <= fe_n;
            busy       <= (cnt_n != '0);
`ifdef SERIAL_WORD_RX_PARITY_EN
            pe_q       <= pe_n;
`endif
        end
    end

endmodule

// File: tb/tb_serial_word_rx.sv
// Scoreboard bench for serial_word_rx (WIDTH=8); expected words queued as frames are driven.
module tb_serial_word_rx;
    localparam int WIDTH = 8;
`ifdef SERIAL_WORD_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FRAME = WIDTH + (PAR ? 1 : 0);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en  = 1'b0;
    logic             d   = 1'b0;
    logic [WIDTH-1:0] word_out;
    logic             word_valid, frame_err, parity_err, busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int fe_cnt   = 0;
    int exp_fe   = 0;
    logic [8:0] exp_q[$];   // {parity_err, word}
    int         vcyc[$];

    serial_word_rx #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .en(en), .d(d),
        .word_out(word_out), .word_valid(word_valid), .frame_err(frame_err),
        .parity_err(parity_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Monitor: every word_valid must match the head of the scoreboard.
    always @(negedge clk) begin
        if (word_valid) begin
            vcyc.push_back(cyc);
            if (exp_q.size() == 0) check("unexpected_valid", 32'(word_out), 32'hdead);
            else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("word", 32'(word_out), 32'(e[7:0]));
                check("parity_err", 32'(parity_err), 32'(e[8]));
            end
            check("valid_and_err", 32'(frame_err), 32'd0);
        end
        if (frame_err) fe_cnt++;
    end

    // One bit per call; returns #1 after the sampling edge.
    task automatic drive(input logic e, input logic b);
        en = e;
        d  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w, input logic pbit);
        for (int i = WIDTH - 1; i >= 0; i--) drive(1'b1, w[i]);
        if (PAR) drive(1'b1, pbit);
    endtask

    task automatic expect_word(input logic [7:0] w, input logic pbit);
        logic perr;
        perr = PAR ? ((^w) ^ pbit) : 1'b0;
        exp_q.push_back({perr, w});
    endtask

    initial begin
        // 1: reset with en/d high
        rst = 1'b1;
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        check("rst_word", 32'(word_out), 32'd0);
        check("rst_valid", 32'(word_valid), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_perr", 32'(parity_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // 2: single word A5
        expect_word(8'hA5, ^8'hA5);
        send_word(8'hA5, ^8'hA5);
        check("a5_valid", 32'(word_valid), 32'd1);
        check("a5_word", 32'(word_out), 32'hA5);
        drive(1'b0, 1'b0);
        check("a5_valid_pulse", 32'(word_valid), 32'd0);
        check("a5_busy_after", 32'(busy), 32'd0);

        // 3: back-to-back 3C, C3
        vcyc.delete();
        expect_word(8'h3C, ^8'h3C);
        expect_word(8'hC3, ^8'hC3);
        send_word(8'h3C, ^8'h3C);
        check("b2b_busy_mid", 32'(busy), 32'd0);
        send_word(8'hC3, ^8'hC3);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        check("b2b_count", 32'(vcyc.size()), 32'd2);
        if (vcyc.size() == 2) check("b2b_gap", 32'(vcyc[1] - vcyc[0]), 32'(FRAME));
        check("b2b_ferr", 32'(fe_cnt), 32'(exp_fe));

        // 4: abort after 5 bits
        expect_word(8'hA5, ^8'hA5);
        send_word(8'hA5, ^8'hA5);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1);
        check("abort_busy", 32'(busy), 32'd1);
        drive(1'b0, 1'b0);
        exp_fe++;
        check("abort_ferr_pulse", 32'(frame_err), 32'd1);
        check("abort_word_held", 32'(word_out), 32'hA5);
        check("abort_busy_after", 32'(busy), 32'd0);
        drive(1'b0, 1'b0);
        check("abort_ferr_cnt", 32'(fe_cnt), 32'(exp_fe));
        expect_word(8'h01, ^8'h01);
        send_word(8'h01, ^8'h01);
        drive(1'b0, 1'b0);

        // 5: reset mid-frame
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0);
        rst = 1'b1;
        drive(1'b0, 1'b0);
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_word", 32'(word_out), 32'd0);
        drive(1'b0, 1'b0);
        check("midrst_ferr_cnt", 32'(fe_cnt), 32'(exp_fe));
        expect_word(8'hFF, ^8'hFF);
        send_word(8'hFF, ^8'hFF);
        drive(1'b0, 1'b0);
        check("ff_word", 32'(word_out), 32'hFF);

        // 6: parity / 9-bit stimulus
        if (PAR) begin
            expect_word(8'hA5, 1'b0);
            send_word(8'hA5, 1'b0);
            drive(1'b0, 1'b0);
            expect_word(8'hA5, 1'b1);
            send_word(8'hA5, 1'b1);
            check("par_bad_flag", 32'(parity_err), 32'd1);
            drive(1'b0, 1'b0);
            check("par_flag_pulse", 32'(parity_err), 32'd0);
        end else begin
            expect_word(8'hA5, 1'b0);
            send_word(8'hA5, 1'b0);
            drive(1'b1, 1'b1);
            check("ninth_bit_busy", 32'(busy), 32'd1);
            drive(1'b0, 1'b0);
            exp_fe++;
            check("ninth_bit_abort", 32'(frame_err), 32'd1);
        end
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        check("final_ferr_cnt", 32'(fe_cnt), 32'(exp_fe));
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected done");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/serial_word_rx.md
Name: serial_word_rx

Overview:
Receive-side counterpart of the team's registered enable/data bit path. Consumes a 1-bit serial stream framed by `en`, sent MSB-first one bit per clock. Reassembles the bits into WIDTH-bit words and flags aborted frames. Sits at the far end of the `en`/`d` link and hands parallel words to downstream logic.

Parameters:
- WIDTH, 8, data bits per word; legal range >= 2.
- CNT_W, $clog2(WIDTH+1), width of the internal bit counter; derived from WIDTH, not overridden.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  frame-valid; `d` is sampled only on edges where en=1.
- d  input  1  serial data bit, MSB first.
- word_out  output  WIDTH  last completed word; held until the next completion.
- word_valid  output  1  one-cycle pulse when word_out is updated.
- frame_err  output  1  one-cycle pulse when a frame is aborted mid-word.
- parity_err  output  1  parity mismatch pulse; constant 0 unless the option is compiled in.
- busy  output  1  high while a partial frame is held (bit count != 0).

Behaviour:
- Reset:
  - Synchronous, active-high, sampled on the clk rising edge.
  - Has priority over every other input.
  - Clears word_out, word_valid, frame_err, parity_err, shift register and bit count to 0.
  - A reset mid-frame discards the partial word silently: no frame_err, no word_valid.
- All outputs are registered.
- States: IDLE (count=0) and SHIFT (count 1..FRAME-1).
  - FRAME = WIDTH without the option, WIDTH+1 with it.
- IDLE:
  - en=0: stay in IDLE, no pulses.
  - en=1: shift in d, count=1, go to SHIFT.
- SHIFT, en=1, count < FRAME-1: shift d in at the LSB, increment count.
- SHIFT, en=1, count = FRAME-1 (final bit):
  - On that edge, word_out <= {shreg, d} (data bits only), word_valid <= 1, count <= 0.
  - word_valid is high during the following cycle only.
  - Latency: word visible one cycle after the last bit is sampled.
- Back-to-back frames: with en held high continuously, a new frame starts on the very next edge. The result is one word_valid every FRAME cycles, with no gap cycle required.
- SHIFT, en=0 (abort):
  - frame_err <= 1 for one cycle, count <= 0, partial data discarded.
  - word_out keeps its previous value.
- word_valid and frame_err are never asserted in the same cycle.
- busy = (count != 0), registered with the counter.
- Bit ordering: the first bit received ends up at word_out[WIDTH-1].

Optional Feature:
Macro: SERIAL_WORD_RX_PARITY_EN
- Defined:
  - Each frame is WIDTH data bits followed by one even-parity bit.
  - On completion, word_out gets the data bits and word_valid pulses as normal.
  - parity_err pulses in the same cycle if the XOR of the data bits and the parity bit is 1.
  - Aborting during the parity bit is a frame_err, like any other abort.
- Not defined:
  - Frame is WIDTH bits; parity_err is tied to 0.
  - A bit following WIDTH data bits starts a new frame.

Test Plan:
1. Reset: rst=1 for 2 cycles with en=1, d=1 -> all outputs 0, busy=0; the first frame after rst deasserts is received intact.
2. Single word (WIDTH=8): en=1 for 8 cycles, d = 1,0,1,0,0,1,0,1 -> one cycle later word_out=8'hA5 and word_valid=1 for exactly 1 cycle; busy=0 afterwards.
3. Back-to-back: en=1 for 16 cycles carrying 8'h3C then 8'hC3 -> two word_valid pulses exactly 8 cycles apart, with word_out=3C then C3; frame_err never asserted.
4. Abort: receive 8'hA5, then en=1 for 5 bits, then en=0 -> frame_err=1 for 1 cycle, no word_valid, word_out stays A5; a following full frame 8'h01 gives word_out=01.
5. Reset mid-frame: after 4 bits of a frame, rst=1 for 1 cycle -> no frame_err, no word_valid, busy=0; the next frame 8'hFF gives word_out=FF.
6. Parity (macro defined):
   - Send 8'hA5 plus parity bit 0 -> word_valid=1, parity_err=0.
   - Send 8'hA5 plus parity bit 1 -> word_valid=1, parity_err=1.
   - Macro undefined, same 9-bit stimulus -> valid word after bit 8; bit 9 sets busy=1.
